readout_serializer: RTL and testbench

Downstream stage of the 512-bit pixel shift register. On a capture strobe it takes a snapshot of the register's parallel `data_out` word and streams it as a sequence of narrow beats on a valid/ready interface toward the chip output pins. Each beat is marked with frame-start and frame-end flags. The block counts completed frames and flags captures that arrive while a frame is still draining.

---
 rtl/readout_serializer_if.sv | 27 ++
 rtl/readout_serializer.sv | 99 +++++++++
 tb/tb_readout_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/readout_serializer_if.sv
// Beat stream from the readout serializer toward the output pins.
// Master drives data and framing flags; slave returns ready.
interface readout_serializer_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output out_first,
    output out_last
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_first,
    input  out_last
  );
endinterface

// File: rtl/readout_serializer.sv
// Snapshots the pixel shift register word and streams it LSB-first
// as OUT_W-bit beats with frame flags, frame counter and overrun flag.
module readout_serializer #(
  parameter int WIDTH = 512,
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture,
  input  logic [WIDTH-1:0]    data_in,
  readout_serializer_if.master bus,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_count
);

  localparam int BEATS = WIDTH / OUT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             accept;
  logic             at_last;

  assign accept  = (state_q == SEND) && bus.out_ready;
  assign at_last = (idx_q == LAST_IDX);

  // Buffer shifts right on each accept so the live beat is always
  // in the low OUT_W bits; idx only tracks framing.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          buf_d   = data_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept && at_last) begin
          cnt_d = cnt_q + 16'd1;
          if (capture) begin
            buf_d = data_in;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) begin
            buf_d = buf_q >> OUT_W;
            idx_d = idx_q + IDX_W'(1);
          end
          if (capture) begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy          = (state_q == SEND);
  assign overrun       = ovr_q;
  assign frame_count   = cnt_q;
  assign bus.out_valid = busy;
  assign bus.out_data  = busy ? buf_q[OUT_W-1:0] : '0;
  assign bus.out_first = busy && (idx_q == '0);
  assign bus.out_last  = busy && at_last;

endmodule

// File: tb/tb_readout_serializer.sv
// Randomised and directed bench for readout_serializer against a
// frame-level reference model (WIDTH=512, OUT_W=8).
module tb_readout_serializer;

  localparam int W  = 512;
  localparam int OW = 8;
  localparam int NB = W / OW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          capture = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          busy;
  logic          overrun;
  logic [15:0]   frame_count;

  readout_serializer_if #(.OUT_W(OW)) bus ();

  readout_serializer #(.WIDTH(W), .OUT_W(OW)) dut (
    .clk(clk),
    .reset(reset),
    .capture(capture),
    .data_in(data_in),
    .bus(bus),
    .busy(busy),
    .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference: which word is in flight, which byte is showing.
  bit           m_busy = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_idx = 0;
  logic [15:0]  m_cnt = '0;
  bit           m_ovr = 1'b0;

  logic [7:0] got[NB];
  int         got_n = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    if (bus.out_valid && bus.out_ready) begin
      if (got_n < NB) got[got_n] = bus.out_data;
      got_n++;
    end
    if (reset) begin
      m_busy = 0; m_idx = 0; m_cnt = '0; m_ovr = 0;
    end else if (!m_busy) begin
      if (capture) begin
        m_word = data_in; m_idx = 0; m_busy = 1;
      end
    end else begin
      acc = bus.out_ready;
      if (acc && m_idx == NB - 1) begin
        m_cnt = m_cnt + 16'd1;
        if (capture) begin
          m_word = data_in; m_idx = 0;
        end else begin
          m_busy = 0;
        end
      end else begin
        if (acc) m_idx++;
        if (capture) m_ovr = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed;
    if (chk_en) begin
      ed = m_busy ? m_word[m_idx*8 +: 8] : 8'h00;
      check("valid", 64'(bus.out_valid), 64'(m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("frame_count", 64'(frame_count), 64'(m_cnt));
      check("data", 64'(bus.out_data), 64'(ed));
      check("first", 64'(bus.out_first),
            64'(m_busy && m_idx == 0));
      check("last", 64'(bus.out_last),
            64'(m_busy && m_idx == NB - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] w);
    got_n = 0;
    capture = 1'b1;
    data_in = w;
    tick();
    capture = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    while (bus.out_valid && guard < 4000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    bus.out_ready = 1'b1;
    if (guard >= 4000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  initial begin
    logic [W-1:0] w, w2;
    logic [15:0]  c0;
    int           bad;
    int           bits[5] = '{0, 7, 8, 255, 511};

    bus.out_ready = 1'b1;
    capture = 1'b1;
    data_in = {W{1'b1}};
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_count", 64'(frame_count), 64'd0);
    reset = 1'b0;
    capture = 1'b0;
    tick();

    foreach (bits[k]) begin
      w = '0;
      w[bits[k]] = 1'b1;
      start(w);
      drain(0);
      check("sb_beats", 64'(got_n), 64'(NB));
      bad = 0;
      for (int b = 0; b < NB; b++) begin
        if (b == bits[k] / 8) begin
          if (got[b] != 8'(1 << (bits[k] % 8))) bad++;
        end else if (got[b] != 8'h00) bad++;
      end
      check("sb_pattern", 64'(bad), 64'd0);
    end
    check("sb_count", 64'(frame_count), 64'd5);

    for (int n = 0; n < NB; n++) w[n*8 +: 8] = 8'(n);
    start(w);
    drain(1);
    check("bp_beats", 64'(got_n), 64'(NB));
    bad = 0;
    for (int n = 0; n < NB; n++) if (got[n] != 8'(n)) bad++;
    check("bp_pattern", 64'(bad), 64'd0);

    c0 = frame_count;
    w2 = ~w;
    start(w);
    for (int n = 0; n < NB - 1; n++) tick();
    check("b2b_last", 64'(bus.out_last), 64'd1);
    capture = 1'b1;
    data_in = w2;
    tick();
    capture = 1'b0;
    check("b2b_first", 64'(bus.out_first), 64'd1);
    check("b2b_data", 64'(bus.out_data), 64'(w2[7:0]));
    check("b2b_ovr", 64'(overrun), 64'd0);
    check("b2b_count", 64'(frame_count), 64'(c0 + 16'd1));
    got_n = 0;
    drain(0);
    check("b2b_beats", 64'(got_n), 64'(NB));

    c0 = frame_count;
    start(w);
    for (int n = 0; n < 10; n++) tick();
    capture = 1'b1;
    data_in = w2;
    tick();
    capture = 1'b0;
    drain(0);
    bad = 0;
    for (int n = 0; n < NB; n++) if (got[n] != 8'(n)) bad++;
    check("ovr_data", 64'(bad), 64'd0);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_count", 64'(frame_count), 64'(c0 + 16'd1));

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = $urandom;
      start(w);
      drain(1);
      check("rnd_beats", 64'(got_n), 64'(NB));
    end

    start(w);
    for (int n = 0; n < 30; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_valid", 64'(bus.out_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_count", 64'(frame_count), 64'd0);
    check("mid_ovr", 64'(overrun), 64'd0);
    w2 = 512'h0123;
    start(w2);
    check("mid_first", 64'(bus.out_first), 64'd1);
    check("mid_data", 64'(bus.out_data), 64'h23);
    drain(0);
    check("mid_restart", 64'(frame_count), 64'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
